seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_pkg.sv | 24 ++
 rtl/seq_det_shift.sv | 64 ++++++
 rtl/seq_detector_parammodule.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_detector_pkg.sv
// ============================================================================
// Module  : seq_detector_pkg
// Brief   : State type and state encoding constants for seq_detector_param.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detector_pkg;

    localparam int unsigned c_st_w = 2;

    localparam logic [c_st_w-1:0] c_st_uncfg = 2'd0;
    localparam logic [c_st_w-1:0] c_st_hunt  = 2'd1;
    localparam logic [c_st_w-1:0] c_st_match = 2'd2;

    typedef enum logic [c_st_w-1:0] {
        ST_UNCFG = c_st_uncfg,
        ST_HUNT  = c_st_hunt,
        ST_MATCH = c_st_match
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_det_shift.sv
// ============================================================================
// Module  : seq_det_shift
// Brief   : History shift register, saturating fill counter and length-masked
//           pattern compare; o_match is combinational on the accepted bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_shift #(
    parameter int PAT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_shift,
    input  logic                         i_din,
    input  logic                         i_overlap,
    input  logic [PAT_W-1:0]             i_pat,
    input  logic [$clog2(PAT_W+1)-1:0]   i_len,
    output logic                         o_match
);

    localparam int L_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] r_hist_q, w_hist_d, w_hist_new, w_mask;
    logic [L_W-1:0]   r_fill_q, w_fill_d, w_fill_new;
    logic             w_match;

    always_comb begin
        w_hist_new = {r_hist_q[PAT_W-2:0], i_din};
        w_fill_new = (r_fill_q == L_W'(PAT_W)) ? r_fill_q : r_fill_q + L_W'(1);
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
        w_match = i_shift && (w_fill_new >= i_len) &&
                  ((w_hist_new & w_mask) == (i_pat & w_mask));

        w_hist_d = r_hist_q;
        w_fill_d = r_fill_q;
        if (i_clear) begin
            w_hist_d = '0;
            w_fill_d = '0;
        end else if (i_shift) begin
            w_hist_d = w_hist_new;
            // Non-overlapping mode restarts the fill so no bit serves two matches
            w_fill_d = (w_match && !i_overlap) ? '0 : w_fill_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_q <= '0;
            r_fill_q <= '0;
        end else begin
            r_hist_q <= w_hist_d;
            r_fill_q <= w_fill_d;
        end
    end

    assign o_match = w_match;

endmodule

`default_nettype wire

// File: rtl/seq_detector_parammodule.sv
// ============================================================================
// Module  : seq_detector_param
// Brief   : Configurable serial pattern detector with Moore match flag.
//           Define SEQ_DETECTOR_CNT_EN to build the saturating match counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             dout,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int L_W = $clog2(PAT_W + 1);

    state_e           r_state_q, w_state_d;
    logic [PAT_W-1:0] r_pat_q, w_pat_d;
    logic [L_W-1:0]   r_len_q, w_len_d;
    logic             r_cfg_err_q;
    logic             w_len_ok, w_load_ok, w_load_bad, w_accept, w_match;

    // A load always wins over a coincident data bit, even when rejected
    assign w_len_ok   = (pat_len != '0) && (int'(pat_len) <= PAT_W);
    assign w_load_ok  = cfg_load && w_len_ok;
    assign w_load_bad = cfg_load && !w_len_ok;
    assign w_accept   = din_valid && !cfg_load && (r_state_q != ST_UNCFG);

    seq_det_shift #(.PAT_W(PAT_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_load_ok),
        .i_shift  (w_accept),
        .i_din    (din),
        .i_overlap(overlap),
        .i_pat    (r_pat_q),
        .i_len    (r_len_q),
        .o_match  (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_UNCFG;
            r_pat_q     <= '0;
            r_len_q     <= '0;
            r_cfg_err_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pat_q     <= w_pat_d;
            r_len_q     <= w_len_d;
            r_cfg_err_q <= w_load_bad;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_pat_d   = r_pat_q;
        w_len_d   = r_len_q;
        if (w_load_ok) begin
            w_state_d = ST_HUNT;
            w_pat_d   = pat;
            w_len_d   = pat_len[L_W-1:0];
        end else if (!w_load_bad) begin
            case (r_state_q)
                ST_UNCFG: w_state_d = ST_UNCFG;
                ST_HUNT,
                ST_MATCH: w_state_d = (w_accept && w_match) ? ST_MATCH : ST_HUNT;
                default:  w_state_d = ST_UNCFG;
            endcase
        end
    end

    always_comb begin
        dout    = (r_state_q == ST_MATCH);
        cfg_err = r_cfg_err_q;
    end

`ifdef SEQ_DETECTOR_CNT_EN
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (w_load_ok) begin
            w_cnt_d = '0;
        end else if (w_accept && w_match && (r_cnt_q != '1)) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign match_cnt = r_cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

`default_nettype wire
